// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the program-memory loader.
package rom_loader_pkg;

   localparam int unsigned WORD_W = 16;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned PC_W   = 15;

   localparam logic [WORD_W-1:0] NOP_WORD = 16'h0000;

   typedef enum logic [2:0] {
      LEN_HI,
      LEN_LO,
      DATA_HI,
      DATA_LO,
      CSUM_HI,
      CSUM_LO,
      RUN,
      ERROR
   } state_e;

endpackage

// File: rtl/rom_loader_instruction_ram.sv
// Simple dual-port instruction RAM: one synchronous write port, one registered read port
// with a synchronous output clear, shaped for block-RAM inference.
module instruction_ram
   import rom_loader_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned DATA_W     = WORD_W
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic                  rd_clr,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_W-1:0]     rdata
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Read-first: a read of the address being written returns the old word.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      if (rd_clr) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/rom_loader.sv
// Loads a length-prefixed big-endian byte stream into instruction RAM, holds the CPU in
// reset until done, then serves instructions. Optional checksum: ROM_LOADER_CHECKSUM_EN.
module rom_loader
   import rom_loader_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [BYTE_W-1:0] rx_data,
   input  logic              rx_valid,
   input  logic [PC_W-1:0]   pc,
   output logic [WORD_W-1:0] instruction,
   output logic              cpu_reset,
   output logic              loaded,
   output logic              error
);

   // Address counter is one bit wider than the word count so overflow never wraps.
   localparam int unsigned CNT_W = WORD_W + 1;
   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

`ifdef ROM_LOADER_CHECKSUM_EN
   localparam state_e POST_DATA = CSUM_HI;
`else
   localparam state_e POST_DATA = RUN;
`endif

   state_e              state_q, state_d;
   logic [BYTE_W-1:0]   hi_q, hi_d;
   logic [WORD_W-1:0]   rem_q, rem_d;
   logic [CNT_W-1:0]    addr_q, addr_d;
   logic                cpu_reset_q, cpu_reset_d;
   logic                loaded_q, loaded_d;
   logic [WORD_W-1:0]   word_c;
   logic                we_c;
   logic                ovf_c;
   logic [WORD_W-1:0]   rdata_c;
   logic                unused_pc_c;
`ifdef ROM_LOADER_CHECKSUM_EN
   logic [WORD_W-1:0]   sum_q, sum_d;
   logic                error_q, error_d;
`endif

   assign word_c      = {hi_q, rx_data};
   assign ovf_c       = (addr_q >= CNT_W'(DEPTH));
   assign unused_pc_c = ^pc[PC_W-1:ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= LEN_HI;
         hi_q        <= '0;
         rem_q       <= '0;
         addr_q      <= '0;
         cpu_reset_q <= 1'b1;
         loaded_q    <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
         sum_q       <= '0;
         error_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         hi_q        <= hi_d;
         rem_q       <= rem_d;
         addr_q      <= addr_d;
         cpu_reset_q <= cpu_reset_d;
         loaded_q    <= loaded_d;
`ifdef ROM_LOADER_CHECKSUM_EN
         sum_q       <= sum_d;
         error_q     <= error_d;
`endif
      end
   end

   // Byte-stream parser; every state moves only on an accepted strobe.
   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      rem_d   = rem_q;
      addr_d  = addr_q;
      we_c    = 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      if (rx_valid) begin
         case (state_q)
            LEN_HI: begin
               hi_d    = rx_data;
               state_d = LEN_LO;
            end
            LEN_LO: begin
               addr_d  = '0;
               rem_d   = word_c;
`ifdef ROM_LOADER_CHECKSUM_EN
               sum_d   = '0;
`endif
               state_d = (word_c == '0) ? POST_DATA : DATA_HI;
            end
            DATA_HI: begin
               hi_d    = rx_data;
               state_d = DATA_LO;
            end
            DATA_LO: begin
               we_c    = ~ovf_c;
               addr_d  = addr_q + CNT_W'(1);
               rem_d   = rem_q - WORD_W'(1);
`ifdef ROM_LOADER_CHECKSUM_EN
               sum_d   = sum_q + word_c;
`endif
               state_d = (rem_q == WORD_W'(1)) ? POST_DATA : DATA_HI;
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            CSUM_HI: begin
               hi_d    = rx_data;
               state_d = CSUM_LO;
            end
            CSUM_LO: begin
               state_d = (word_c == sum_q) ? RUN : ERROR;
            end
`endif
            default: ;
         endcase
      end
      cpu_reset_d = (state_d != RUN);
      loaded_d    = (state_d == RUN);
`ifdef ROM_LOADER_CHECKSUM_EN
      error_d     = (state_d == ERROR);
`endif
   end

   // Output clear tracks the next cpu_reset so instruction reads NOP exactly while held.
   instruction_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_W     (WORD_W)
   ) u_ram (
      .clk    (clk),
      .we     (we_c & ~reset),
      .waddr  (addr_q[ADDR_WIDTH-1:0]),
      .wdata  (word_c),
      .rd_clr (reset | cpu_reset_d),
      .raddr  (pc[ADDR_WIDTH-1:0]),
      .rdata  (rdata_c)
   );

   assign instruction = rdata_c;
   assign cpu_reset   = cpu_reset_q;
   assign loaded      = loaded_q;
`ifdef ROM_LOADER_CHECKSUM_EN
   assign error       = error_q;
`else
   assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader with a byte-stream reference model checked every cycle.
module tb_rom_loader;

   localparam int DEPTH = 4096;
`ifdef ROM_LOADER_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic [14:0] pc = 15'h0000;
   logic [15:0] instruction;
   logic        cpu_reset;
   logic        loaded;
   logic        error;

   always #5 clk = ~clk;

   rom_loader #(.ADDR_WIDTH(12)) dut (
      .clk         (clk),
      .reset       (reset),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .pc          (pc),
      .instruction (instruction),
      .cpu_reset   (cpu_reset),
      .loaded      (loaded),
      .error       (error)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: interprets the stream by byte position since the last reset.
   logic [15:0] m_mem [DEPTH];
   bit          m_vld [DEPTH];
   int          nb = 0;
   int          n_words = 0;
   logic [7:0]  lenhi = 0, hi = 0, chi = 0;
   logic [15:0] sum = 0;
   bit          csum_ok = 0;
   bit          running = 0, err = 0;
   bit          exp_cpu_reset = 1, exp_loaded = 0, exp_error = 0, exp_iv = 1;
   logic [15:0] exp_instr = 16'h0000;
   bit          started = 0;

   always @(posedge clk) begin : model_p
      logic [15:0] rd;
      bit          rv;
      int          a, k, j;
      logic [15:0] w;
      a  = int'(pc[11:0]);
      rd = m_mem[a];
      rv = m_vld[a];
      if (reset) begin
         nb = 0; running = 0; err = 0;
      end else if (rx_valid && !running && !err) begin
         k = nb;
         if (k == 0) lenhi = rx_data;
         else if (k == 1) begin
            n_words = int'({lenhi, rx_data});
            sum = 16'h0000;
         end else if (k < 2 + 2 * n_words) begin
            if (k % 2 == 0) hi = rx_data;
            else begin
               w = {hi, rx_data};
               sum = sum + w;
               j = (k - 3) / 2;
               if (j < DEPTH) begin
                  m_mem[j] = w;
                  m_vld[j] = 1;
               end
            end
         end else if (k == 2 + 2 * n_words) chi = rx_data;
         else csum_ok = ({chi, rx_data} == sum);
         nb++;
         if (nb >= 2 && nb == 2 + 2 * n_words + (CSUM_EN ? 2 : 0)) begin
            if (CSUM_EN && !csum_ok) err = 1;
            else running = 1;
         end
      end
      exp_cpu_reset = !running;
      exp_loaded    = running;
      exp_error     = err;
      exp_iv        = exp_cpu_reset || rv;
      exp_instr     = exp_cpu_reset ? 16'h0000 : rd;
      started       = 1;
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (started) begin
         chk("cpu_reset", 16'(cpu_reset), 16'(exp_cpu_reset));
         chk("loaded", 16'(loaded), 16'(exp_loaded));
         chk("error", 16'(error), 16'(exp_error));
         if (exp_iv) chk("instruction", instruction, exp_instr);
      end
   end

   logic [15:0] img[$];
   logic [7:0]  bq[$];

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic build_bytes();
      logic [15:0] n, s;
      n = 16'(img.size());
      s = 16'h0000;
      bq = {};
      bq.push_back(n[15:8]);
      bq.push_back(n[7:0]);
      foreach (img[i]) begin
         bq.push_back(img[i][15:8]);
         bq.push_back(img[i][7:0]);
         s = s + img[i];
      end
      if (CSUM_EN) begin
         bq.push_back(s[15:8]);
         bq.push_back(s[7:0]);
      end
   endtask

   task automatic send_bq(input int gap);
      foreach (bq[i]) send_byte(bq[i], gap);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic read_pc(input logic [14:0] p, input logic [15:0] exp, input string name);
      pc = p;
      @(negedge clk);
      chk(name, instruction, exp);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_cpu_reset", 16'(cpu_reset), 16'h1);
      chk("rst_loaded", 16'(loaded), 16'h0);
      chk("rst_error", 16'(error), 16'h0);
      chk("rst_instruction", instruction, 16'h0000);
      reset = 1'b0;

      // Two-word image, back-to-back strobes
      img = '{16'h1234, 16'hABCD};
      build_bytes();
      send_bq(0);
      chk("t2_loaded", 16'(loaded), 16'h1);
      chk("t2_cpu_reset", 16'(cpu_reset), 16'h0);
      chk("t2_model_ram0", m_mem[0], 16'h1234);
      read_pc(15'h0001, 16'hABCD, "t2_pc1");
      read_pc(15'h0000, 16'h1234, "t2_pc0");
      read_pc(15'h1001, 16'hABCD, "t2_alias");

      // Empty image keeps prior contents
      pulse_reset();
      img = {};
      build_bytes();
      send_bq(0);
      chk("t3_loaded", 16'(loaded), 16'h1);
      read_pc(15'h0000, 16'h1234, "t3_pc0");

      // Reset mid-load, then a fresh image
      pulse_reset();
      pc = 15'h0000;
      bq = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
      send_bq(0);
      reset = 1'b1;
      @(negedge clk);
      chk("t4_cpu_reset", 16'(cpu_reset), 16'h1);
      chk("t4_loaded", 16'(loaded), 16'h0);
      chk("t4_instruction", instruction, 16'h0000);
      reset = 1'b0;
      img = '{16'hBEEF};
      build_bytes();
      send_bq(0);
      read_pc(15'h0000, 16'hBEEF, "t4_pc0");
      read_pc(15'h0001, 16'hABCD, "t4_pc1");

      // Strobe during reset is dropped; spaced strobes
      reset = 1'b1;
      rx_valid = 1'b1;
      rx_data = 8'h00;
      @(negedge clk);
      reset = 1'b0;
      rx_valid = 1'b0;
      img = '{16'hCAFE};
      build_bytes();
      send_bq(1);
      chk("t5_loaded", 16'(loaded), 16'h1);
      read_pc(15'h0000, 16'hCAFE, "t5_pc0");

      // Bytes in RUN are ignored
      repeat (5) send_byte(8'($urandom), 0);
      chk("t6_loaded", 16'(loaded), 16'h1);
      read_pc(15'h0000, 16'hCAFE, "t6_pc0");
      read_pc(15'h0001, 16'hABCD, "t6_pc1");

      // Overflow: more words than RAM depth, no wrap
      pulse_reset();
      pc = 15'h0000;
      img = {};
      for (int i = 0; i < DEPTH + 2; i++) img.push_back(16'(i + 1));
      build_bytes();
      for (int i = 0; i < bq.size() - 1; i++) send_byte(bq[i], 0);
      chk("t7_not_yet", 16'(loaded), 16'h0);
      send_byte(bq[bq.size() - 1], 0);
      chk("t7_loaded", 16'(loaded), 16'h1);
      read_pc(15'h0000, 16'h0001, "t7_pc0");
      read_pc(15'h0001, 16'h0002, "t7_pc1");
      read_pc(15'h0FFF, 16'h1000, "t7_pc_last");
      read_pc(15'h0FFE, 16'h0FFF, "t7_pc_last_m1");

`ifdef ROM_LOADER_CHECKSUM_EN
      pulse_reset();
      pc = 15'h0000;
      bq = '{8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
      send_bq(0);
      chk("t8_good_loaded", 16'(loaded), 16'h1);
      chk("t8_good_error", 16'(error), 16'h0);
      pulse_reset();
      bq = '{8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h04};
      send_bq(0);
      repeat (3) @(negedge clk);
      chk("t8_bad_error", 16'(error), 16'h1);
      chk("t8_bad_cpu_reset", 16'(cpu_reset), 16'h1);
      chk("t8_bad_loaded", 16'(loaded), 16'h0);
      read_pc(15'h0000, 16'h0000, "t8_bad_instr");
`endif

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rom_loader.md
# rom_loader

Program-memory stage feeding the Hack CPU. Receives a program image as a byte stream from the serial receiver and writes it into an on-chip instruction RAM. Holds the CPU in reset until the image is complete. Then serves `instruction` for each `pc` the CPU presents.

## Interface
- `ADDR_WIDTH`, 12, instruction RAM address bits; depth is 2^ADDR_WIDTH words.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; restarts the loader.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` valid this cycle. There is no backpressure: every strobe is consumed.
- `pc`  in  15  CPU program counter.
- `instruction`  out  16  registered word at `pc`.
- `cpu_reset`  out  1  high while loading or on error; drives the CPU `reset`.
- `loaded`  out  1  high once the image is complete and the CPU is running.
- `error`  out  1  high after a checksum failure (only with macro).

## Operation
- Stream format, big-endian throughout:
  - LEN_HI, LEN_LO: 16-bit word count N.
  - N × (DATA_HI, DATA_LO): the data words.
  - Optional CSUM_HI, CSUM_LO (see Configuration).
- States: LEN_HI → LEN_LO → DATA_HI ↔ DATA_LO → [CSUM_HI → CSUM_LO] → RUN; ERROR.
  - State advances only on a cycle with `rx_valid`.
- LEN_LO accepted:
  - N = 0 → go to RUN (or CSUM_HI), no writes.
  - N > 0 → go to DATA_HI; write address counter cleared to 0.
- DATA_HI accepted: byte stored in the high-byte latch.
- DATA_LO accepted:
  - RAM write of {latch, rx_data} at the address counter, in the same cycle.
  - Address counter increments; remaining count decrements.
  - Remaining count 0 → leave the data phase.
- Overflow: when address ≥ 2^ADDR_WIDTH, words are consumed and counted but not written. There is no wrap into low addresses.
- RUN:
  - `cpu_reset` = 0, `loaded` = 1.
  - Further `rx_valid` bytes are ignored.
  - Exit only via `reset`.
- ERROR:
  - `cpu_reset` = 1, `error` = 1.
  - Bytes ignored; exit only via `reset`.
- Read path: `instruction` <= RAM[pc[ADDR_WIDTH-1:0]] every cycle. Upper `pc` bits are ignored (address aliases).
  - While `cpu_reset` = 1, `instruction` is forced to 0x0000.
- RAM contents are not cleared by `reset`. A reload overwrites only addresses 0..N-1.

## Timing
- Reset values:
  - `instruction` = 0x0000, `cpu_reset` = 1, `loaded` = 0, `error` = 0.
  - State = LEN_HI; counters = 0.
- `reset` together with `rx_valid`: reset wins and the byte is dropped.
- `reset` mid-load: back to LEN_HI next cycle; a partially written image stays in RAM.
- Write latency: the word is in RAM at the edge where DATA_LO is accepted. A read of that address returns it from the following cycle.
- `cpu_reset` falls and `loaded` rises on the clock edge that accepts the final byte. They are registered, so they are visible the cycle after that byte's strobe.
- Read latency: 1 cycle from `pc` to `instruction`.
  - The first cycle after `cpu_reset` falls, `instruction` = RAM[pc = 0].
- Back-to-back strobes (every cycle) are supported in every state.

## Configuration
- `ROM_LOADER_CHECKSUM_EN` defined:
  - After the data words, a 16-bit checksum is expected: the modulo-2^16 sum of all N data words, including discarded overflow words.
  - Match → RUN. Mismatch → ERROR.
- Undefined:
  - No checksum phase; the last data byte, or LEN_LO when N = 0, goes directly to RUN.
  - `error` is tied to 0.

## Structure
- Shared package `rom_loader_pkg`:
  - state enum (LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO, RUN, ERROR);
  - `WORD_W` = 16, `BYTE_W` = 8, `PC_W` = 15;
  - `NOP_WORD` = 16'h0000.
- Sub-module `instruction_ram`:
  - one synchronous write port and one synchronous registered read port;
  - parameterised by ADDR_WIDTH;
  - written so it infers block RAM.
- FSM, counters, latch and checksum accumulator live in `rom_loader`.

## Test plan
- Stream 00 02 12 34 AB CD → RAM[0] = 0x1234, RAM[1] = 0xABCD; `cpu_reset` low and `loaded` high the cycle after the last strobe; `pc` = 1 → `instruction` = 0xABCD one cycle later.
- Stream 00 00 (macro off) → RUN after 2 bytes, no writes; `pc` = 0 returns the prior contents.
- Stream 00 03 11 22 33 then `reset` → LEN_HI, `cpu_reset` = 1, `instruction` = 0; a fresh stream 00 01 BE EF then loads RAM[0] = 0xBEEF.
- ADDR_WIDTH = 2, N = 6, words 0x0001..0x0006 → RAM[0..3] = 1..4, RAM[0] not overwritten by 5; RUN reached after 14 bytes.
- Macro on, stream 00 02 00 01 00 02 00 03 → RUN; same stream with checksum 00 04 → ERROR, `error` = 1, `cpu_reset` stays 1.
- In RUN, inject 5 strobes with random data → RAM and outputs unchanged.
